lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR with XNOR feedback: the next generation of the team's fixed 6-bit LFSR. Generalised in width, tap polynomial and bits-per-clock. Adds clock enable, seed load, lock-up protection and on-line period measurement. Used as a PN/scrambler source and as a self-checking test-pattern generator in DSP datapaths.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_step.sv | 19 +
 rtl/lfsr_gen.sv | 103 ++++++++++
 tb/tb_lfsr_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: default tap masks and the XNOR lock-up state helper.
package lfsr_pkg;

   localparam logic [5:0] LFSR6_TAPS = 6'b110000;
   localparam logic [7:0] LFSR8_TAPS = 8'b10111000;

   // All-ones value of the given width; this is the XNOR lock-up state.
   function automatic logic [31:0] all_ones(input int unsigned width);
      if (width >= 32) begin
         return 32'hFFFF_FFFF;
      end
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of a Fibonacci LFSR with XNOR feedback.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int unsigned         WIDTH = 6,
   parameter logic [WIDTH-1:0]    TAPS  = LFSR6_TAPS
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   logic fb;

   always_comb begin
      fb     = ~^(state_i & TAPS);
      next_o = {state_i[WIDTH-2:0], fb};
   end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised XNOR Fibonacci LFSR with seed load, lock-up protection and period measurement.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 6,
   parameter logic [WIDTH-1:0] TAPS  = LFSR6_TAPS,
   parameter int unsigned      STEPS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] y,
   output logic             bit_out,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             period_vld,
   output logic             lock_err
);

   localparam logic [WIDTH-1:0] LockState = WIDTH'(all_ones(WIDTH));

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             vld_q, vld_d;
   logic             wrap_q, wrap_d;
   logic             lock_err_q, lock_err_d;
   logic [WIDTH-1:0] seed_eff;
   logic [WIDTH-1:0] chain [STEPS+1];

   assign chain[0] = state_q;

   for (genvar i = 0; i < STEPS; i++) begin : g_step
      lfsr_step #(
         .WIDTH (WIDTH),
         .TAPS  (TAPS)
      ) u_step (
         .state_i (chain[i]),
         .next_o  (chain[i+1])
      );
   end

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      cnt_d      = cnt_q;
      period_d   = period_q;
      vld_d      = vld_q;
      wrap_d     = 1'b0;
      lock_err_d = 1'b0;
      seed_eff   = (seed == LockState) ? '0 : seed;

      if (load) begin
         // Period keeps its stale value; only the valid flag drops.
         state_d    = seed_eff;
         start_d    = seed_eff;
         cnt_d      = '0;
         vld_d      = 1'b0;
         lock_err_d = (seed == LockState);
      end else if (en) begin
         state_d = chain[STEPS];
         if (chain[STEPS] == start_q) begin
            period_d = cnt_q + WIDTH'(1);
            vld_d    = 1'b1;
            wrap_d   = 1'b1;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= '0;
         start_q    <= '0;
         cnt_q      <= '0;
         period_q   <= '0;
         vld_q      <= 1'b0;
         wrap_q     <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         vld_q      <= vld_d;
         wrap_q     <= wrap_d;
         lock_err_q <= lock_err_d;
      end
   end

   assign y          = state_q;
   assign bit_out    = state_q[WIDTH-1];
   assign wrap       = wrap_q;
   assign period     = period_q;
   assign period_vld = vld_q;
   assign lock_err   = lock_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 6-bit instance plus 8-bit instances with STEPS=1 and 8.
module tb_lfsr_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, load;
   logic [5:0] seed;
   logic [5:0] y, period;
   logic       bit_out, wrap, period_vld, lock_err;

   logic       en8;
   logic [7:0] y81, y88, per81, per88;
   logic       bo81, bo88, wr81, wr88, vld81, vld88, le81, le88;

   int         total = 0;
   int         bad   = 0;
   logic [31:0] m6, m81, m88;
   logic [5:0] hand [6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};

   always #5 clk = ~clk;

   lfsr_gen u_dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .load       (load),
      .seed       (seed),
      .y          (y),
      .bit_out    (bit_out),
      .wrap       (wrap),
      .period     (period),
      .period_vld (period_vld),
      .lock_err   (lock_err)
   );

   lfsr_gen #(.WIDTH(8), .TAPS(8'b10111000), .STEPS(1)) u_w8s1 (
      .clk        (clk),
      .reset      (reset),
      .en         (en8),
      .load       (1'b0),
      .seed       (8'h00),
      .y          (y81),
      .bit_out    (bo81),
      .wrap       (wr81),
      .period     (per81),
      .period_vld (vld81),
      .lock_err   (le81)
   );

   lfsr_gen #(.WIDTH(8), .TAPS(8'b10111000), .STEPS(8)) u_w8s8 (
      .clk        (clk),
      .reset      (reset),
      .en         (en8),
      .load       (1'b0),
      .seed       (8'h00),
      .y          (y88),
      .bit_out    (bo88),
      .wrap       (wr88),
      .period     (per88),
      .period_vld (vld88),
      .lock_err   (le88)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference step: inverted parity of tapped stages shifted into stage 1.
   function automatic logic [31:0] mstep(input logic [31:0] s, input int w,
                                         input logic [31:0] taps);
      logic p;
      p = 1'b1;
      for (int k = 0; k < w; k++) begin
         if (taps[k]) p = p ^ s[k];
      end
      return ((s << 1) | {31'b0, p}) & ((32'd1 << w) - 32'd1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n enabled cycles on the 6-bit instance, wrap expected only on the last one.
   task automatic run_en(input int n, input string tag);
      en = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         m6 = mstep(m6, 6, 32'h30);
         chk({tag, "_y"}, y, m6);
         chk({tag, "_wrap"}, wrap, (i == n - 1) ? 1 : 0);
      end
      en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_y"}, y, 0);
      chk({tag, "_bit_out"}, bit_out, 0);
      chk({tag, "_wrap"}, wrap, 0);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_vld"}, period_vld, 0);
      chk({tag, "_lock_err"}, lock_err, 0);
   endtask

   initial begin
      reset = 1'b0;
      en    = 1'b0;
      en8   = 1'b0;
      load  = 1'b0;
      seed  = 6'h00;
      #12;
      chk_all_zero("reset");
      chk("reset_y8", y81, 0);

      @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("first6_y", y, hand[i]);
         chk("first6_bit_out", bit_out, hand[i][5]);
         chk("first6_wrap", wrap, 0);
      end
      m6 = 32'h3E;
      run_en(57, "wrap1");
      chk("wrap1_y0", y, 0);
      chk("wrap1_period", period, 63);
      chk("wrap1_vld", period_vld, 1);
      run_en(63, "wrap2");
      chk("wrap2_period", period, 63);
      chk("wrap2_vld", period_vld, 1);

      // All-ones seed is replaced by zero.
      load = 1'b1;
      seed = 6'h3F;
      tick();
      chk("lock_y", y, 0);
      chk("lock_err", lock_err, 1);
      chk("lock_vld", period_vld, 0);
      chk("lock_period_kept", period, 63);
      load = 1'b0;
      tick();
      chk("lock_err_pulse", lock_err, 0);
      chk("lock_hold_y", y, 0);

      load = 1'b1;
      seed = 6'h15;
      tick();
      chk("seed15_y", y, 6'h15);
      chk("seed15_lock_err", lock_err, 0);
      load = 1'b0;
      m6 = 32'h15;
      run_en(63, "seed15");
      chk("seed15_period", period, 63);
      chk("seed15_vld", period_vld, 1);

      // load has priority over en.
      load = 1'b1;
      en   = 1'b1;
      seed = 6'h2A;
      tick();
      chk("ld_en_y", y, 6'h2A);
      chk("ld_en_wrap", wrap, 0);
      load = 1'b0;
      en   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_y", y, 6'h2A);
         chk("hold_wrap", wrap, 0);
      end
      m6 = 32'h2A;
      run_en(63, "resume");
      chk("resume_period", period, 63);
      chk("resume_vld", period_vld, 1);

      // Asynchronous reset mid-run while y=0x1F.
      load = 1'b1;
      seed = 6'h0F;
      tick();
      load = 1'b0;
      en   = 1'b1;
      tick();
      en   = 1'b0;
      chk("pre_arst_y", y, 6'h1F);
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("arst");
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;
      tick();
      en    = 1'b0;
      chk("post_arst_y", y, 6'h01);

      // 8-bit instances, STEPS=1 and STEPS=8 from the zero start state.
      m81 = 0;
      m88 = 0;
      en8 = 1'b1;
      for (int i = 0; i < 255; i++) begin
         tick();
         m81 = mstep(m81, 8, 32'hB8);
         for (int k = 0; k < 8; k++) m88 = mstep(m88, 8, 32'hB8);
         chk("w8s1_y", y81, m81);
         chk("w8s8_y", y88, m88);
         chk("w8s1_wrap", wr81, (i == 254) ? 1 : 0);
         chk("w8s8_wrap", wr88, (i == 254) ? 1 : 0);
      end
      en8 = 1'b0;
      chk("w8s1_period", per81, 255);
      chk("w8s1_vld", vld81, 1);
      chk("w8s8_period", per88, 255);
      chk("w8s8_vld", vld88, 1);
      chk("w8s8_lock_err", le88, 0);
      chk("w8s8_bit_out", bo88, y88[7]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
